bus_arbiter_rr: RTL and testbench

//  Round-robin arbiter for the shared system bus (BUS_addr/BUS_data/BUS_RW).
//  Bus masters (I-cache on DMA[0], D-cache on DMA[1], others above) raise a request line.
//  The arbiter grants exactly one master, holds the grant until that master releases, and

---
 rtl/bus_arbiter_rr.sv | 147 ++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with a turnaround gap between owners. A watchdog revokes the
// grant from an owner stalled on a silent slave.
module bus_arbiter_rr #(
  parameter int N          = 8,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [N-1:0]         DMA,
  output logic [N-1:0]         grant,
  output logic                 BUS_req,
  input  logic                 BUS_ready,
  output logic [$clog2(N)-1:0] owner,
  output logic                 bus_timeout
);

  localparam int IW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
  localparam logic [WW-1:0] WDOG_EXP = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WDOG_MAX = {WW{1'b1}};
  localparam logic [GW-1:0] GAP_INIT = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  localparam state_t ST_AFTER_OWN = (GAP_CYCLES > 0) ? ST_TURN : ST_IDLE;

  state_t        state_r;
  logic [N-1:0]  grant_r;
  logic          bus_req_r;
  logic [IW-1:0] owner_r;
  logic [IW-1:0] last_r;
  logic          bus_timeout_r;
  logic [WW-1:0] wdog_r;
  logic [N-1:0]  mask_r;
  logic [GW-1:0] gap_cnt_r;

  logic [N-1:0]  req_s;
  logic [IW:0]   cand_s;
  logic [IW-1:0] idx_s;
  logic [IW-1:0] win_s;
  logic          found_s;

  // Round-robin search: first unmasked requester at or after last_r+1, wrapping at N.
  always_comb begin
    req_s   = DMA & ~mask_r;
    cand_s  = {(IW+1){1'b0}};
    idx_s   = {IW{1'b0}};
    win_s   = {IW{1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand_s = {1'b0, last_r} + (IW+1)'(i) + {{IW{1'b0}}, 1'b1};
      if (cand_s >= (IW+1)'(N)) begin
        cand_s = cand_s - (IW+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      idx_s = cand_s[IW-1:0];
      if (!found_s && req_s[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Arbitration state machine, watchdog, request mask and all registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r       <= ST_IDLE;
      grant_r       <= {N{1'b0}};
      bus_req_r     <= 1'b0;
      owner_r       <= {IW{1'b0}};
      last_r        <= LAST_RST;
      bus_timeout_r <= 1'b0;
      wdog_r        <= {WW{1'b0}};
      mask_r        <= {N{1'b0}};
      gap_cnt_r     <= {GW{1'b0}};
    end else begin
      bus_timeout_r <= 1'b0;
      // A masked master is released from the mask once it drops its request.
      mask_r        <= mask_r & DMA;
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            grant_r   <= ONE_HOT0 << win_s;
            bus_req_r <= 1'b1;
            owner_r   <= win_s;
            last_r    <= win_s;
            wdog_r    <= {WW{1'b0}};
            state_r   <= ST_OWN;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_OWN: begin
          if (!DMA[owner_r]) begin
            grant_r   <= {N{1'b0}};
            bus_req_r <= 1'b0;
            gap_cnt_r <= GAP_INIT;
            state_r   <= ST_AFTER_OWN;
          end else if (BUS_ready) begin
            wdog_r    <= {WW{1'b0}};
          end else if (wdog_r == WDOG_EXP) begin
            grant_r       <= {N{1'b0}};
            bus_req_r     <= 1'b0;
            bus_timeout_r <= 1'b1;
            mask_r        <= (mask_r & DMA) | (ONE_HOT0 << owner_r);
            gap_cnt_r     <= GAP_INIT;
            state_r       <= ST_AFTER_OWN;
          end else if (wdog_r != WDOG_MAX) begin
            wdog_r    <= wdog_r + {{(WW-1){1'b0}}, 1'b1};
          end else begin
            wdog_r    <= wdog_r;
          end
        end
        ST_TURN: begin
          if (gap_cnt_r == {GW{1'b0}}) begin
            state_r   <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - {{(GW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          grant_r   <= {N{1'b0}};
          bus_req_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant       = grant_r;
  assign BUS_req     = bus_req_r;
  assign owner       = owner_r;
  assign bus_timeout = bus_timeout_r;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: per-feature tasks plus a grant-order scoreboard.
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] DMA;
  logic [7:0] grant;
  logic       BUS_req;
  logic       BUS_ready;
  logic [2:0] owner;
  logic       bus_timeout;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] prev_grant = 8'h00;

  bus_arbiter_rr #(.N(8), .GAP_CYCLES(1), .TIMEOUT(4)) dut (
    .clk(clk), .clr(clr), .DMA(DMA), .grant(grant), .BUS_req(BUS_req),
    .BUS_ready(BUS_ready), .owner(owner), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    DMA = 8'h00;
    BUS_ready = 1'b1;
    repeat (4) tick();
  endtask

  // Scoreboard: each new ownership must match the next expected grant; invariants every cycle.
  always @(posedge clk) begin
    #1;
    checks++;
    if ($onehot0(grant) !== 1'b1 || BUS_req !== (|grant)) begin
      errors++;
      $display("FAIL invariant: grant=%h BUS_req=%b", grant, BUS_req);
    end
    if (grant !== 8'h00 && grant !== prev_grant && prev_grant !== 8'h00) begin
      checks++;
      errors++;
      $display("FAIL grant_switch: got %h from %h, required a zero cycle between", grant, prev_grant);
    end
    if (grant !== 8'h00 && prev_grant === 8'h00 && exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e) begin
        errors++;
        $display("FAIL grant_order: got %h expected %h", grant, e);
      end
    end
    prev_grant <= grant;
  end

  task automatic test_reset();
    clr = 1'b1; DMA = 8'hFF; BUS_ready = 1'b1;
    tick(); tick();
    checks++;
    if (grant !== 8'h00 || BUS_req !== 1'b0 || owner !== 3'd0 || bus_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset: got grant=%h req=%b owner=%0d to=%b expected 00 0 0 0", grant, BUS_req, owner, bus_timeout);
    end
    exp_q.push_back(8'h01);
    clr = 1'b0;
    tick();
    checks++;
    if (grant !== 8'h01) begin
      errors++;
      $display("FAIL reset_first_grant: got %h expected 01", grant);
    end
    settle();
  endtask

  task automatic test_single_master();
    exp_q.push_back(8'h01);
    DMA = 8'h01;
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (grant !== 8'h01 || BUS_req !== 1'b1) begin
        errors++;
        $display("FAIL single_hold: cycle %0d got %h expected 01", i, grant);
      end
      BUS_ready = ~BUS_ready;
      tick();
    end
    DMA = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant !== 8'h00 || BUS_req !== 1'b0) begin
        errors++;
        $display("FAIL single_release: cycle %0d got %h expected 00", i, grant);
      end
    end
    settle();
  endtask

  task automatic test_fairness();
    int idx;
    clr = 1'b1; tick(); clr = 1'b0;
    for (int k = 0; k < 9; k++) exp_q.push_back(8'h01 << (k % 8));
    DMA = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      idx = k % 8;
      for (int c = 0; c < 10 && grant === 8'h00; c++) tick();
      checks++;
      if (owner !== 3'(idx) || grant === 8'h00) begin
        errors++;
        $display("FAIL fair_owner: got %0d (grant %h) expected %0d", owner, grant, idx);
      end
      tick(); tick();
      DMA[idx] = 1'b0;
      tick();
      checks++;
      if (grant !== 8'h00) begin
        errors++;
        $display("FAIL fair_release: got %h expected 00", grant);
      end
      DMA[idx] = 1'b1;
    end
    settle();
  endtask

  task automatic test_pointer_wrap();
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h01);
    DMA = 8'h81;
    for (int c = 0; c < 10 && grant === 8'h00; c++) tick();
    checks++;
    if (grant !== 8'h80) begin
      errors++;
      $display("FAIL wrap_first: got %h expected 80", grant);
    end
    tick();
    DMA = 8'h01;
    tick();
    for (int c = 0; c < 10 && grant === 8'h00; c++) tick();
    checks++;
    if (grant !== 8'h01) begin
      errors++;
      $display("FAIL wrap_second: got %h expected 01", grant);
    end
    settle();
  endtask

  task automatic test_watchdog();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h01);
    DMA = 8'h01; BUS_ready = 1'b0;
    tick();
    DMA = 8'h03;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (grant !== 8'h01 || bus_timeout !== 1'b0) begin
        errors++;
        $display("FAIL wdog_stall: edge %0d got grant=%h to=%b expected 01 0", i, grant, bus_timeout);
      end
    end
    tick();
    checks++;
    if (bus_timeout !== 1'b1 || grant !== 8'h00 || BUS_req !== 1'b0) begin
      errors++;
      $display("FAIL wdog_revoke: got to=%b grant=%h expected 1 00", bus_timeout, grant);
    end
    tick();
    checks++;
    if (bus_timeout !== 1'b0) begin
      errors++;
      $display("FAIL wdog_pulse_width: got %b expected 0", bus_timeout);
    end
    tick();
    checks++;
    if (grant !== 8'h02) begin
      errors++;
      $display("FAIL wdog_next_master: got %h expected 02", grant);
    end
    BUS_ready = 1'b1;
    DMA = 8'h01;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i > 0) begin
        checks++;
        if (grant !== 8'h00) begin
          errors++;
          $display("FAIL wdog_mask: got %h expected 00", grant);
        end
      end
    end
    DMA = 8'h00;
    tick();
    DMA = 8'h01;
    for (int c = 0; c < 10 && grant === 8'h00; c++) tick();
    checks++;
    if (grant !== 8'h01) begin
      errors++;
      $display("FAIL wdog_unmask: got %h expected 01", grant);
    end
    settle();
  endtask

  task automatic test_corner_cases();
    exp_q.push_back(8'h01);
    DMA = 8'h01; BUS_ready = 1'b0;
    for (int c = 0; c < 10 && grant === 8'h00; c++) tick();
    repeat (3) tick();
    DMA = 8'h00;
    tick();
    checks++;
    if (bus_timeout !== 1'b0 || grant !== 8'h00) begin
      errors++;
      $display("FAIL release_vs_timeout: got to=%b grant=%h expected 0 00", bus_timeout, grant);
    end
    settle();
    exp_q.push_back(8'h01);
    DMA = 8'h01; BUS_ready = 1'b0;
    for (int c = 0; c < 10 && grant === 8'h00; c++) tick();
    repeat (3) tick();
    BUS_ready = 1'b1;
    tick();
    BUS_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (grant !== 8'h01 || bus_timeout !== 1'b0) begin
      errors++;
      $display("FAIL ready_clears_wdog: got grant=%h to=%b expected 01 0", grant, bus_timeout);
    end
    settle();
    exp_q.push_back(8'h04);
    DMA = 8'h04;
    for (int c = 0; c < 10 && grant === 8'h00; c++) tick();
    DMA = 8'h0D;
    tick();
    clr = 1'b1;
    tick();
    checks++;
    if (grant !== 8'h00 || BUS_req !== 1'b0 || owner !== 3'd0) begin
      errors++;
      $display("FAIL clr_in_own: got grant=%h req=%b owner=%0d expected 00 0 0", grant, BUS_req, owner);
    end
    exp_q.push_back(8'h01);
    clr = 1'b0;
    tick();
    checks++;
    if (grant !== 8'h01) begin
      errors++;
      $display("FAIL clr_pointer: got %h expected 01", grant);
    end
    settle();
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: bench did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    clr = 1'b1; DMA = 8'h00; BUS_ready = 1'b1;
    test_reset();
    test_single_master();
    test_fairness();
    test_pointer_wrap();
    test_watchdog();
    test_corner_cases();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
